// File: rtl/quad_enc_pkg.sv
// quad_enc_pkg: shared types, direction codes and Gray-sequence helpers for quadrature_encoder_tx.
package quad_enc_pkg;
    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef enum logic {IDLE, DWELL} state_e;

    // ab is {A, B}; CW walks 00 -> 10 -> 11 -> 01, CCW walks the reverse.
    function automatic logic [1:0] gray_next_cw(input logic [1:0] ab);
        return {~ab[0], ab[1]};
    endfunction

    function automatic logic [1:0] gray_next_ccw(input logic [1:0] ab);
        return {ab[0], ~ab[1]};
    endfunction
endpackage

// File: rtl/quadrature_encoder_tx_phase_timer.sv
// phase_timer: up-counter cleared by start_i, counting while en_i, with a one-cycle
// terminal pulse on the last count of every N-cycle period.
module phase_timer #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = N > 1 ? $clog2(N) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = en_i && cnt_q == W'(N - 1);
    assign cnt_d = (start_i || tc_o) ? '0 : en_i ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/quadrature_encoder_tx.sv
// quadrature_encoder_tx: rotary-encoder emulator, one Gray-coded detent per accepted step.
// Optional contact-bounce injection on the changing channel: QUAD_ENC_BOUNCE_INJECT_EN.
module quadrature_encoder_tx
    import quad_enc_pkg::*;
#(
    parameter int PHASE_CYCLES  = 100_000,
    parameter int DETENT_PHASES = 4,
    parameter int POS_W         = 16
`ifdef QUAD_ENC_BOUNCE_INJECT_EN
    ,
    parameter int BOUNCE_COUNT  = 3,
    parameter int BOUNCE_CYCLES = 1000
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_valid,
    input  logic                    step_dir,
    output logic                    step_ready,
    output logic                    enc_a,
    output logic                    enc_b,
    output logic                    busy,
    output logic signed [POS_W-1:0] position
);
    localparam int PLW = $clog2(DETENT_PHASES + 1);

    if (PHASE_CYCLES < 2) begin : g_phase_chk
        $error("PHASE_CYCLES must be at least 2");
    end

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [PLW-1:0]   left_q, left_d;
    logic [1:0]       ab_q, ab_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             accept, advance, done, tc;

    assign step_ready = state_q == IDLE;
    assign busy       = !step_ready;
    assign position   = pos_q;
    assign accept     = step_valid && step_ready;
    // The first transition of a detent fires on the edge right after accept, without waiting a phase.
    assign advance    = state_q == DWELL && left_q != '0 && (left_q == PLW'(DETENT_PHASES) || tc);
    assign done       = state_q == DWELL && left_q == '0 && tc;

    phase_timer #(.N(PHASE_CYCLES)) u_phase (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(accept || advance),
        .en_i   (state_q == DWELL),
        .tc_o   (tc)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        left_d  = left_q;
        ab_d    = ab_q;
        pos_d   = pos_q;
        if (accept) begin
            state_d = DWELL;
            dir_d   = step_dir;
            left_d  = PLW'(DETENT_PHASES);
        end else if (advance) begin
            ab_d   = dir_q == DIR_CW ? gray_next_cw(ab_q) : gray_next_ccw(ab_q);
            left_d = left_q - PLW'(1);
        end else if (done) begin
            state_d = IDLE;
            pos_d   = dir_q == DIR_CW ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_CW;
            left_q  <= '0;
            ab_q    <= 2'b00;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            left_q  <= left_d;
            ab_q    <= ab_d;
            pos_q   <= pos_d;
        end
    end

`ifdef QUAD_ENC_BOUNCE_INJECT_EN
    localparam int BLW = $clog2(2 * BOUNCE_COUNT + 2);

    if (2 * BOUNCE_COUNT * BOUNCE_CYCLES >= PHASE_CYCLES) begin : g_bounce_chk
        $error("bounce train must fit inside one phase");
    end

    logic [BLW-1:0] bleft_q, bleft_d;
    logic           gl_q, gl_d, btc;
    logic [1:0]     mask_q, mask_d, out_q;

    phase_timer #(.N(BOUNCE_CYCLES)) u_bounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(advance),
        .en_i   (bleft_q != '0),
        .tc_o   (btc)
    );

    // Glitches only mask the output; ab_q keeps the true phase so timing is untouched.
    always_comb begin
        bleft_d = bleft_q;
        gl_d    = gl_q;
        mask_d  = mask_q;
        if (advance) begin
            bleft_d = BLW'(2 * BOUNCE_COUNT);
            gl_d    = 1'b0;
            mask_d  = ab_q ^ ab_d;
        end else if (btc) begin
            bleft_d = bleft_q - BLW'(1);
            gl_d    = !gl_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bleft_q <= '0;
            gl_q    <= 1'b0;
            mask_q  <= 2'b00;
            out_q   <= 2'b00;
        end else begin
            bleft_q <= bleft_d;
            gl_q    <= gl_d;
            mask_q  <= mask_d;
            out_q   <= ab_d ^ ({2{gl_d}} & mask_d);
        end
    end

    assign enc_a = out_q[1];
    assign enc_b = out_q[0];
`else
    assign enc_a = ab_q[1];
    assign enc_b = ab_q[0];
`endif
endmodule

// File: tb/tb_quadrature_encoder_tx.sv
// tb_quadrature_encoder_tx: directed and random steps against a timing-schedule model of the
// encoder (detent index and transition times derived from accept edge arithmetic).
module tb_quadrature_encoder_tx;
    localparam int P = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_valid = 1'b0;
    logic       step_dir = 1'b0;
    logic       step_ready, enc_a, enc_b, busy;
    logic [3:0] position;

    int total = 0;
    int bad = 0;

    quadrature_encoder_tx #(.PHASE_CYCLES(P), .DETENT_PHASES(D), .POS_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_valid(step_valid),
        .step_dir  (step_dir),
        .step_ready(step_ready),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .busy      (busy),
        .position  (position)
    );

    always #5 clk = ~clk;

    logic [1:0] cw_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: after an accept at edge S, the phase index has moved min(D, (k-1)/P + 1) places
    // at edge S+k, and the detent completes at edge S + 1 + D*P.
    int         m_edge = 0, m_start = 0, m_idx = 0, m_idx0 = 0, m_acc = 0, k, n;
    bit         m_busy = 0, m_dir = 0;
    logic [3:0] m_pos = 4'd0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0;
            m_idx  = 0;
            m_pos  = 4'd0;
        end else begin
            m_edge++;
            if (m_busy) begin
                k = m_edge - m_start;
                n = (k - 1) / P + 1;
                if (n > D) n = D;
                m_idx = m_dir ? m_idx0 + n : m_idx0 - n;
                if (k == 1 + D * P) begin
                    m_busy = 0;
                    m_pos  = m_dir ? m_pos + 4'd1 : m_pos - 4'd1;
                end
            end else if (step_valid) begin
                m_busy  = 1;
                m_start = m_edge;
                m_dir   = step_dir;
                m_idx0  = m_idx;
                m_acc++;
            end
        end
    end

    int dut_acc = 0, tb_edge = 0;
    int acc_t[$];

    initial forever begin
        @(posedge clk);
        tb_edge++;
        if (rst_n && step_valid && step_ready) begin
            dut_acc++;
            acc_t.push_back(tb_edge);
        end
    end

    logic [1:0] prev_ab = 2'b00;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("ab", {enc_a, enc_b}, cw_seq[m_idx & 3]);
            chk("ready", step_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("position", position, m_pos);
            chk("ab_single_bit", $countones({enc_a, enc_b} ^ prev_ab) <= 1, 1);
        end
        prev_ab = {enc_a, enc_b};
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        step_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_step(input bit dir, input logic [1:0] e1, input logic [1:0] e2,
                              input logic [1:0] e3, input logic [1:0] e4, input logic [3:0] ep);
        @(negedge clk);
        step_valid = 1'b1;
        step_dir   = dir;
        @(negedge clk);
        step_valid = 1'b0;
        chk("lit_busy_after_accept", busy, 1);
        @(negedge clk);
        chk("lit_ab1", {enc_a, enc_b}, e1);
        repeat (3) @(negedge clk);
        chk("lit_ab1_hold", {enc_a, enc_b}, e1);
        @(negedge clk);
        chk("lit_ab2", {enc_a, enc_b}, e2);
        repeat (4) @(negedge clk);
        chk("lit_ab3", {enc_a, enc_b}, e3);
        repeat (4) @(negedge clk);
        chk("lit_ab4", {enc_a, enc_b}, e4);
        repeat (3) @(negedge clk);
        chk("lit_ready_late", step_ready, 0);
        @(negedge clk);
        chk("lit_ready_done", step_ready, 1);
        chk("lit_pos_done", position, ep);
    endtask

    task automatic wait_ready(input string nm);
        int i;
        for (i = 0; i < 100 && !step_ready; i++) @(negedge clk);
        chk(nm, step_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, i;
        do_reset();
        chk("rst_ab", {enc_a, enc_b}, 2'b00);
        chk("rst_ready", step_ready, 1);
        repeat (50) @(negedge clk);
        chk("idle_ab", {enc_a, enc_b}, 2'b00);
        chk("idle_pos", position, 4'd0);
        chk("idle_busy", busy, 0);

        check_step(1'b1, 2'b10, 2'b11, 2'b01, 2'b00, 4'd1);
        do_reset();
        check_step(1'b0, 2'b01, 2'b11, 2'b10, 2'b00, 4'hF);

        do_reset();
        base = dut_acc;
        acc_t.delete();
        @(negedge clk);
        step_valid = 1'b1;
        step_dir   = 1'b1;
        repeat (21) @(negedge clk);
        step_dir = 1'b0;
        repeat (33) @(negedge clk);
        chk("held_ready_third", step_ready, 1);
        step_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_accepts", dut_acc - base, 3);
        chk("held_pos", position, 4'd1);
        if (acc_t.size() == 3) begin
            chk("held_gap1", acc_t[1] - acc_t[0], D * P + 2);
            chk("held_gap2", acc_t[2] - acc_t[1], D * P + 2);
        end else chk("held_accept_log", acc_t.size(), 3);

        do_reset();
        check_step(1'b1, 2'b10, 2'b11, 2'b01, 2'b00, 4'd1);
        @(negedge clk);
        step_valid = 1'b1;
        step_dir   = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_mid_ab", {enc_a, enc_b}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ab", {enc_a, enc_b}, 2'b00);
        chk("abort_ready", step_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_pos", position, 4'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        check_step(1'b1, 2'b10, 2'b11, 2'b01, 2'b00, 4'd1);

        do_reset();
        base = dut_acc;
        @(negedge clk);
        step_valid = 1'b1;
        step_dir   = 1'b1;
        for (i = 0; i < 400 && dut_acc - base < 16; i++) @(negedge clk);
        step_valid = 1'b0;
        chk("wrap_accepts", dut_acc - base, 16);
        wait_ready("wrap_ready_timeout");
        chk("wrap_pos", position, 4'd0);
        chk("wrap_ab", {enc_a, enc_b}, 2'b00);

        do_reset();
        for (i = 0; i < 1500; i++) begin
            @(negedge clk);
            step_valid = $urandom_range(0, 3) == 0;
            step_dir   = 1'($urandom);
        end
        step_valid = 1'b0;
        @(negedge clk);
        wait_ready("rand_ready_timeout");
        chk("rand_accepts", m_acc > 20, 1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
